// File: rtl/riscv_cache_pkg.sv
// riscv_cache_pkg
// Shared cache geometry helpers and the types used by the whole-cache
// maintenance sequencer (riscv_cache_flush_seq).
//   no_of_sets              : sets for a cache of cache_size KBytes,
//                             block_size bits per line, ways ways
//   no_of_block_offset_bits : byte-offset bits inside one line
//   no_of_index_bits        : set index width
//   no_of_tag_bits          : physical address bits left for the tag
//   flush_state_t           : sequencer FSM states
//   flush_mode_t            : sweep flavour (invalidate / writeback+invalidate)
package riscv_cache_pkg;

   typedef enum logic [2:0] {
      FS_IDLE,
      FS_RD,
      FS_CHK,
      FS_WB,
      FS_CLR,
      FS_DONE
   } flush_state_t;

   typedef enum logic {
      MODE_INV,
      MODE_WBINV
   } flush_mode_t;

   // cache_size in KBytes, block_size in bits
   function automatic int no_of_sets(input int cache_size, input int block_size, input int ways);
      return (cache_size * 1024 * 8) / block_size / ways;
   endfunction

   function automatic int no_of_block_offset_bits(input int block_size);
      return $clog2(block_size / 8);
   endfunction

   function automatic int no_of_index_bits(input int sets);
      return $clog2(sets);
   endfunction

   function automatic int no_of_tag_bits(input int plen, input int idx_bits, input int blk_offs_bits);
      return plen - idx_bits - blk_offs_bits;
   endfunction

endpackage

// File: rtl/riscv_cache_flush_seq.sv
// riscv_cache_flush_seq
// Owns the cache tag/status memory during whole-cache maintenance. Leaving
// reset it invalidates every set; on flush_req_i it writes back dirty lines
// and invalidates them, on inval_req_i it invalidates without writeback.
// The cache pipeline is stalled (busy_o) for the whole sweep.
// Ports:
//   clk_i, rst_i            : clock, synchronous active-high reset
//   flush_req_i/inval_req_i : writeback+invalidate / invalidate-only request
//   busy_o, done_o          : pipeline stall, end-of-sweep pulse
//   tag_rd_o, tag_idx_o     : tag/status read strobe and set index
//   tag_valid_i/dirty_i/tag_i : per-way status, one cycle after tag_rd_o
//   tag_clr_o               : clear valid+dirty of all ways at tag_idx_o
//   wb_req_o/way_o/adr_o    : writeback request, one-hot way, line address
//   wb_ack_i                : writeback accepted
module riscv_cache_flush_seq
   import riscv_cache_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int PLEN       = XLEN,
   parameter int SIZE       = 64,
   parameter int BLOCK_SIZE = XLEN,
   parameter int WAYS       = 2,

   localparam int SETS          = no_of_sets(SIZE, BLOCK_SIZE, WAYS),
   localparam int IDX_BITS      = no_of_index_bits(SETS),
   localparam int BLK_OFFS_BITS = no_of_block_offset_bits(BLOCK_SIZE),
   localparam int TAG_BITS      = no_of_tag_bits(PLEN, IDX_BITS, BLK_OFFS_BITS)
)(
   input  logic                     clk_i,
   input  logic                     rst_i,

   input  logic                     flush_req_i,
   input  logic                     inval_req_i,
   output logic                     busy_o,
   output logic                     done_o,

   output logic                     tag_rd_o,
   output logic [IDX_BITS-1:0]      tag_idx_o,
   input  logic [WAYS-1:0]          tag_valid_i,
   input  logic [WAYS-1:0]          tag_dirty_i,
   input  logic [WAYS*TAG_BITS-1:0] tag_tag_i,
   output logic                     tag_clr_o,

   output logic                     wb_req_o,
   output logic [WAYS-1:0]          wb_way_o,
   output logic [PLEN-1:0]          wb_adr_o,
   input  logic                     wb_ack_i
);

   localparam logic [IDX_BITS-1:0] IDX_LAST = IDX_BITS'(SETS - 1);

   flush_state_t              state_q, state_d;
   flush_mode_t               mode_q,  mode_d;
   logic [IDX_BITS-1:0]       idx_q,   idx_d;
   logic [WAYS-1:0]           pend_q,  pend_d;
   logic [WAYS-1:0]           way_q,   way_d;
   logic [WAYS*TAG_BITS-1:0]  tags_q,  tags_d;
   // set for the CHK cycle that directly follows RD: tag memory data is live
   logic                      fresh_q, fresh_d;

   logic [WAYS-1:0]           pend_cur;
   logic [TAG_BITS-1:0]       wb_tag;

   function automatic logic [WAYS-1:0] lowest_one_hot(input logic [WAYS-1:0] v);
      logic [WAYS-1:0] r;
      r = '0;
      for (int unsigned w = 0; w < WAYS; w++) begin
         if (v[w] && (r == '0)) r[w] = 1'b1;
      end
      return r;
   endfunction

   //------------------------------------------------------------------
   // State register
   //------------------------------------------------------------------
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= FS_RD;       // reset starts the invalidate sweep
         mode_q  <= MODE_INV;
         idx_q   <= '0;
         pend_q  <= '0;
         way_q   <= '0;
         tags_q  <= '0;
         fresh_q <= 1'b0;
      end else begin
         state_q <= state_d;
         mode_q  <= mode_d;
         idx_q   <= idx_d;
         pend_q  <= pend_d;
         way_q   <= way_d;
         tags_q  <= tags_d;
         fresh_q <= fresh_d;
      end
   end

   //------------------------------------------------------------------
   // Next state
   //------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      mode_d   = mode_q;
      idx_d    = idx_q;
      pend_d   = pend_q;
      way_d    = way_q;
      tags_d   = tags_q;
      fresh_d  = 1'b0;
      pend_cur = '0;

      case (state_q)
         FS_IDLE: begin
            if (flush_req_i) begin
               mode_d  = MODE_WBINV;
               idx_d   = '0;
               state_d = FS_RD;
            end else if (inval_req_i) begin
               mode_d  = MODE_INV;
               idx_d   = '0;
               state_d = FS_RD;
            end
         end

         FS_RD: begin
            fresh_d = 1'b1;
            state_d = FS_CHK;
         end

         // first visit after RD takes the dirty mask from the tag memory;
         // later visits (after a writeback) only re-examine the stored mask
         FS_CHK: begin
            if (fresh_q) begin
               pend_cur = (mode_q == MODE_WBINV) ? (tag_valid_i & tag_dirty_i) : '0;
               tags_d   = tag_tag_i;
            end else begin
               pend_cur = pend_q;
            end
            pend_d = pend_cur;
            if (pend_cur != '0) begin
               way_d   = lowest_one_hot(pend_cur);
               state_d = FS_WB;
            end else begin
               state_d = FS_CLR;
            end
         end

         FS_WB: begin
            if (wb_ack_i) begin
               pend_d  = pend_q & ~way_q;
               state_d = FS_CHK;
            end
         end

         FS_CLR: begin
            if (idx_q == IDX_LAST) begin
               state_d = FS_DONE;
            end else begin
               idx_d   = idx_q + IDX_BITS'(1);
               state_d = FS_RD;
            end
         end

         FS_DONE: state_d = FS_IDLE;

         default: state_d = FS_IDLE;
      endcase
   end

   //------------------------------------------------------------------
   // Outputs, decoded from registers only
   //------------------------------------------------------------------
   always_comb begin
      wb_tag = '0;
      for (int unsigned w = 0; w < WAYS; w++) begin
         if (way_q[w]) wb_tag = tags_q[w*TAG_BITS +: TAG_BITS];
      end
   end

   always_comb begin
      busy_o    = (state_q != FS_IDLE);
      done_o    = (state_q == FS_DONE);
      tag_rd_o  = (state_q == FS_RD);
      tag_clr_o = (state_q == FS_CLR);
      tag_idx_o = idx_q;
      wb_req_o  = (state_q == FS_WB);
      wb_way_o  = '0;
      wb_adr_o  = '0;
      if (state_q == FS_WB) begin
         wb_way_o = way_q;
         wb_adr_o = {wb_tag, idx_q, {BLK_OFFS_BITS{1'b0}}};
      end
   end

   //------------------------------------------------------------------
   // Interface properties
   //------------------------------------------------------------------
   a_wb_onehot : assert property (@(posedge clk_i) disable iff (rst_i)
      wb_req_o |-> $onehot(wb_way_o));

   a_wb_stable : assert property (@(posedge clk_i) disable iff (rst_i)
      (wb_req_o && !wb_ack_i) |=> (wb_req_o && $stable(wb_way_o) && $stable(wb_adr_o)));

endmodule

// File: tb/tb_riscv_cache_flush_seq.sv
// tb_riscv_cache_flush_seq
// Self-checking bench: a tag memory model answers reads and clears, a
// writeback responder acks after a chosen delay, and the observed event
// stream (reads, writebacks, clears) plus sweep length is compared against
// a list derived from the memory contents and the request type.
module tb_riscv_cache_flush_seq;
   import riscv_cache_pkg::*;

   localparam int XLEN       = 32;
   localparam int PLEN       = 32;
   localparam int SIZE       = 1;     // 1 KByte
   localparam int BLOCK_SIZE = 256;   // 32-byte lines
   localparam int WAYS       = 2;
   localparam int SETS       = 16;
   localparam int IDX_BITS   = 4;
   localparam int TAG_BITS   = 23;

   logic                     clk = 1'b0;
   logic                     rst_i = 1'b1;
   logic                     flush_req_i = 1'b0;
   logic                     inval_req_i = 1'b0;
   logic                     busy_o, done_o, tag_rd_o, tag_clr_o, wb_req_o;
   logic [IDX_BITS-1:0]      tag_idx_o;
   logic [WAYS-1:0]          tag_valid_i = '0;
   logic [WAYS-1:0]          tag_dirty_i = '0;
   logic [WAYS*TAG_BITS-1:0] tag_tag_i = '0;
   logic [WAYS-1:0]          wb_way_o;
   logic [PLEN-1:0]          wb_adr_o;
   logic                     wb_ack_i = 1'b0;

   riscv_cache_flush_seq #(
      .XLEN(XLEN), .PLEN(PLEN), .SIZE(SIZE), .BLOCK_SIZE(BLOCK_SIZE), .WAYS(WAYS)
   ) dut (
      .clk_i(clk), .rst_i(rst_i),
      .flush_req_i(flush_req_i), .inval_req_i(inval_req_i),
      .busy_o(busy_o), .done_o(done_o),
      .tag_rd_o(tag_rd_o), .tag_idx_o(tag_idx_o),
      .tag_valid_i(tag_valid_i), .tag_dirty_i(tag_dirty_i), .tag_tag_i(tag_tag_i),
      .tag_clr_o(tag_clr_o),
      .wb_req_o(wb_req_o), .wb_way_o(wb_way_o), .wb_adr_o(wb_adr_o), .wb_ack_i(wb_ack_i)
   );

   always #5 clk = ~clk;

   int unsigned cyc = 0;
   always @(posedge clk) cyc++;

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // tag memory model
   logic                m_valid [SETS][WAYS];
   logic                m_dirty [SETS][WAYS];
   logic [TAG_BITS-1:0] m_tag   [SETS][WAYS];

   logic [63:0] ev_log[$];
   logic [63:0] exp_ev[$];
   int          dly_q[$];

   // event kinds: 0 = tag read, 1 = writeback, 2 = clear
   function automatic logic [63:0] mk_ev(input int kind, input int idx, input logic [1:0] way,
                                         input logic [31:0] adr);
      return (64'(kind) << 40) | (64'(idx) << 36) | (64'(way) << 32) | 64'(adr);
   endfunction

   // responders and event logger, all on the falling edge
   bit          wb_act = 1'b0;
   int          wb_cnt = 0;
   int          cur_dly = 0;
   logic [1:0]  held_way;
   logic [31:0] held_adr;
   logic [3:0]  held_idx;

   always @(negedge clk) begin
      if (tag_rd_o === 1'b1) begin
         ev_log.push_back(mk_ev(0, int'(tag_idx_o), 2'b00, 32'h0));
         for (int w = 0; w < WAYS; w++) begin
            tag_valid_i[w] = m_valid[tag_idx_o][w];
            tag_dirty_i[w] = m_dirty[tag_idx_o][w];
            tag_tag_i[w*TAG_BITS +: TAG_BITS] = m_tag[tag_idx_o][w];
         end
      end
      if (tag_clr_o === 1'b1) begin
         ev_log.push_back(mk_ev(2, int'(tag_idx_o), 2'b00, 32'h0));
         for (int w = 0; w < WAYS; w++) begin
            m_valid[tag_idx_o][w] = 1'b0;
            m_dirty[tag_idx_o][w] = 1'b0;
         end
      end
      if (wb_req_o === 1'b1) begin
         if (!wb_act) begin
            wb_act   = 1'b1;
            wb_cnt   = 0;
            cur_dly  = (dly_q.size() > 0) ? dly_q.pop_front() : 0;
            held_way = wb_way_o;
            held_adr = wb_adr_o;
            held_idx = tag_idx_o;
            ev_log.push_back(mk_ev(1, int'(tag_idx_o), wb_way_o, wb_adr_o));
         end else begin
            check("wb_hold", 64'({wb_way_o, wb_adr_o, tag_idx_o}), 64'({held_way, held_adr, held_idx}));
         end
         wb_ack_i = (wb_cnt == cur_dly);
         wb_cnt++;
      end else begin
         wb_act   = 1'b0;
         wb_ack_i = 1'b0;
      end
   end

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   // Expected event list and sweep length from the current memory contents
   task automatic build_exp(input bit wbinv, input int forced_dly, output int exp_cyc);
      int d;
      exp_ev.delete();
      dly_q.delete();
      exp_cyc = 3 * SETS + 1;
      for (int s = 0; s < SETS; s++) begin
         exp_ev.push_back(mk_ev(0, s, 2'b00, 32'h0));
         if (wbinv) begin
            for (int w = 0; w < WAYS; w++) begin
               if (m_valid[s][w] && m_dirty[s][w]) begin
                  d = (forced_dly >= 0) ? forced_dly : int'($urandom_range(0, 4));
                  dly_q.push_back(d);
                  exp_cyc += d + 2;
                  exp_ev.push_back(mk_ev(1, s, 2'(1 << w), {m_tag[s][w], 4'(s), 5'b0}));
               end
            end
         end
         exp_ev.push_back(mk_ev(2, s, 2'b00, 32'h0));
      end
   endtask

   task automatic fill_mem(input bit rand_valid, input bit rand_dirty);
      for (int s = 0; s < SETS; s++) begin
         for (int w = 0; w < WAYS; w++) begin
            m_valid[s][w] = rand_valid ? 1'($urandom) : 1'b1;
            m_dirty[s][w] = rand_dirty ? 1'($urandom) : 1'b0;
            m_tag[s][w]   = TAG_BITS'($urandom);
         end
      end
   endtask

   task automatic start_req(input bit fl, input bit iv, output int t0);
      tick();
      flush_req_i = fl;
      inval_req_i = iv;
      t0 = int'(cyc);
      ev_log.delete();
      tick();
      flush_req_i = 1'b0;
      inval_req_i = 1'b0;
   endtask

   task automatic wait_done(input string tg, input int t0, input int exp_cyc, input int extra_pulse);
      int  n = 0;
      bit  seen = 1'b0;
      bit  any_valid = 1'b0;
      int  m;
      while (n < 3000) begin
         tick();
         n++;
         flush_req_i = (n == extra_pulse);
         if (done_o === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      flush_req_i = 1'b0;
      check({tg, "_done_seen"}, 64'(seen), 64'(1));
      check({tg, "_cycles"}, 64'(int'(cyc) - t0), 64'(exp_cyc));
      tick();
      check({tg, "_busy_after"}, 64'(busy_o), 64'(0));
      check({tg, "_done_pulse"}, 64'(done_o), 64'(0));
      repeat (4) tick();
      check({tg, "_idle"}, 64'(busy_o), 64'(0));
      check({tg, "_n_events"}, 64'(ev_log.size()), 64'(exp_ev.size()));
      m = (ev_log.size() < exp_ev.size()) ? ev_log.size() : exp_ev.size();
      for (int i = 0; i < m; i++) check({tg, "_event"}, ev_log[i], exp_ev[i]);
      for (int s = 0; s < SETS; s++)
         for (int w = 0; w < WAYS; w++)
            if (m_valid[s][w]) any_valid = 1'b1;
      check({tg, "_all_invalid"}, 64'(any_valid), 64'(0));
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, exp_cyc, n, kind;

      // reset sweep, every line valid, dirty ignored
      fill_mem(1'b0, 1'b1);
      build_exp(1'b0, -1, exp_cyc);
      rst_i = 1'b1;
      tick();
      tick();
      t0 = int'(cyc);
      ev_log.delete();
      tick();
      rst_i = 1'b0;
      check("rst_busy",   64'(busy_o),    64'(1));
      check("rst_tag_rd", 64'(tag_rd_o),  64'(1));
      check("rst_idx",    64'(tag_idx_o), 64'(0));
      check("rst_clr",    64'(tag_clr_o), 64'(0));
      check("rst_wb_req", 64'(wb_req_o),  64'(0));
      check("rst_wb_way", 64'(wb_way_o),  64'(0));
      check("rst_wb_adr", 64'(wb_adr_o),  64'(0));
      check("rst_done",   64'(done_o),    64'(0));
      wait_done("reset", t0, exp_cyc, 0);
      check("reset_len49", 64'(exp_cyc), 64'(49));

      // set 5 way 1 dirty, tag 0x12, ack 3 cycles late
      fill_mem(1'b0, 1'b0);
      m_dirty[5][1] = 1'b1;
      m_tag[5][1]   = 23'h12;
      build_exp(1'b1, 3, exp_cyc);
      start_req(1'b1, 1'b0, t0);
      wait_done("flush_s5", t0, exp_cyc, 0);

      // set 3 both ways dirty: way0 then way1, clear only after second ack
      fill_mem(1'b0, 1'b0);
      m_dirty[3][0] = 1'b1;
      m_dirty[3][1] = 1'b1;
      build_exp(1'b1, -1, exp_cyc);
      start_req(1'b1, 1'b0, t0);
      wait_done("flush_s3", t0, exp_cyc, 0);

      // invalidate-only with dirty lines present
      fill_mem(1'b0, 1'b1);
      build_exp(1'b0, -1, exp_cyc);
      start_req(1'b0, 1'b1, t0);
      wait_done("inval", t0, exp_cyc, 0);

      // both requests together, plus a stray flush mid-sweep
      fill_mem(1'b0, 1'b0);
      m_dirty[9][0] = 1'b1;
      build_exp(1'b1, -1, exp_cyc);
      start_req(1'b1, 1'b1, t0);
      wait_done("both_req", t0, exp_cyc, 10);

      // reset while writing back set 7
      fill_mem(1'b0, 1'b0);
      m_dirty[7][0] = 1'b1;
      build_exp(1'b1, 100, exp_cyc);
      start_req(1'b1, 1'b0, t0);
      n = 0;
      while (!(wb_req_o === 1'b1 && tag_idx_o == 4'd7) && n < 500) begin
         tick();
         n++;
      end
      check("rst_wb_reached", 64'(wb_req_o === 1'b1 && tag_idx_o == 4'd7), 64'(1));
      rst_i = 1'b1;
      build_exp(1'b0, -1, exp_cyc);
      t0 = int'(cyc);
      ev_log.delete();
      tick();
      rst_i = 1'b0;
      check("rstwb_wb_req", 64'(wb_req_o),  64'(0));
      check("rstwb_tag_rd", 64'(tag_rd_o),  64'(1));
      check("rstwb_idx",    64'(tag_idx_o), 64'(0));
      wait_done("rst_wb", t0, exp_cyc, 0);

      // randomized sweeps
      for (int it = 0; it < 6; it++) begin
         fill_mem(1'b1, 1'b1);
         kind = int'($urandom_range(0, 2));
         build_exp(kind != 1, -1, exp_cyc);
         start_req(kind != 1, kind != 0, t0);
         wait_done("random", t0, exp_cyc, 0);
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/riscv_cache_flush_seq.md
# riscv_cache_flush_seq

Sequencer that owns the cache tag/status memory during whole-cache maintenance. After reset it invalidates every set. On request it either writes back dirty lines and invalidates them, or invalidates without writeback. It sits beside the cache tag stage: it consumes that stage's registered cacheflush indication, and stalls the cache pipeline for the whole sweep.

## Interface
Parameters:
- XLEN, 32, data width
- PLEN, XLEN, physical address width
- SIZE, 64, cache size (riscv_cache_pkg units)
- BLOCK_SIZE, XLEN, line size
- WAYS, 2, associativity
- SETS, IDX_BITS, TAG_BITS, BLK_OFFS_BITS: localparams from the riscv_cache_pkg functions no_of_sets, no_of_index_bits, no_of_tag_bits and no_of_block_offset_bits.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset. One clock; reset is synchronous and active-high.
- flush_req_i  in  1  writeback+invalidate request (from the tag stage cacheflush_o)
- inval_req_i  in  1  invalidate-only request
- busy_o  out  1  pipeline stall; high whenever state != IDLE
- done_o  out  1  one-cycle pulse at end of sweep
- tag_rd_o  out  1  tag/status read strobe
- tag_idx_o  out  IDX_BITS  set index for read/clear
- tag_valid_i  in  WAYS  per-way valid bit, 1 cycle after tag_rd_o
- tag_dirty_i  in  WAYS  per-way dirty bit, same timing
- tag_tag_i  in  WAYS*TAG_BITS  per-way stored tag; way w occupies [w*TAG_BITS +: TAG_BITS]
- tag_clr_o  out  1  clear valid and dirty of all ways at tag_idx_o
- wb_req_o  out  1  writeback request
- wb_way_o  out  WAYS  one-hot way being written back
- wb_adr_o  out  PLEN  {tag, idx, BLK_OFFS_BITS'0}
- wb_ack_i  in  1  writeback accepted/complete

## Operation
- FSM states: IDLE, RD, CHK, WB, CLR, DONE.
- Registers: idx (IDX_BITS), mode (WBINV or INV), pend (WAYS dirty mask), captured tags.
- Reset: state=RD, idx=0, mode=INV, pend=0. This produces an automatic invalidate sweep.
- IDLE:
  - flush_req_i gives mode=WBINV.
  - Otherwise inval_req_i gives mode=INV.
  - On either request: idx=0, go RD.
  - flush_req_i wins if both are high.
- RD: tag_rd_o=1, tag_idx_o=idx, go CHK.
- CHK:
  - On entry from RD, capture pend = tag_valid_i & tag_dirty_i (forced to 0 when mode=INV) and capture tag_tag_i.
  - If pend != 0, go WB with the lowest-index set bit of pend. Otherwise go CLR.
- WB:
  - wb_req_o=1; wb_way_o, wb_adr_o, tag_idx_o held stable until wb_ack_i.
  - On wb_ack_i: clear that bit of pend and go CHK, which re-evaluates pend without re-reading the tag memory.
- CLR:
  - tag_clr_o=1 for one cycle at idx.
  - If idx==SETS-1 go DONE; else idx+1, go RD.
- DONE: done_o=1, go IDLE.
- Requests seen in any state except IDLE are ignored (not queued). The requester must hold or reissue.
- rst_i in any state aborts the current sweep, drops wb_req_o, and restarts the invalidate sweep from idx 0.

## Timing
- Outputs are decoded from state/registers; no output depends combinationally on inputs.
- Values in the first cycle after reset: busy_o=1, tag_rd_o=1, tag_idx_o=0, tag_clr_o=0, wb_req_o=0, wb_way_o=0, wb_adr_o=0, done_o=0.
- Clean sweep takes 3*SETS+1 cycles from the request cycle: RD,CHK,CLR per set, plus DONE.
  - done_o is high in cycle 3*SETS+1.
  - busy_o falls the cycle after done_o.
- Each dirty line adds (cycles until wb_ack_i, at least 1) + 1 CHK cycle.
- wb_ack_i in the same cycle wb_req_o rises counts as acceptance.
- idx wraps only by reset or a new request. Overflow past SETS-1 never occurs.

## Structure
- riscv_cache_pkg: add the flush_state_t enum and the mode typedef. The existing SETS/IDX/TAG helper functions are reused.
- No sub-module. Lowest-set-bit way selection is a local automatic function producing a one-hot vector.

## Test plan
Use parameters giving SETS=16, WAYS=2.
- Reset release, memory model all valid:
  - tag_rd_o at idx 0..15 and tag_clr_o at each idx.
  - done_o exactly 49 cycles after reset deassertion; no wb_req_o.
- flush_req_i with set 5 way1 dirty, tag 0x12:
  - One wb_req_o, wb_way_o=2'b10, wb_adr_o={0x12,5,0}.
  - After wb_ack_i delayed 3 cycles, sweep continues; total 49+4+1 cycles.
- flush_req_i with set 3 both ways dirty:
  - Writebacks way0 then way1, tag_idx_o=3 stable throughout.
  - tag_clr_o for set 3 only after the second ack.
- inval_req_i with dirty lines present: no wb_req_o; 49-cycle sweep.
- flush_req_i and inval_req_i high together: WBINV mode (dirty line written back). A second flush_req_i during busy produces no additional sweep.
- rst_i asserted while wb_req_o high at idx 7:
  - Next cycle wb_req_o=0, tag_rd_o=1, tag_idx_o=0.
  - Full invalidate sweep follows.
